multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control unit: a 14-state FSM that sequences fetch, decode, memory, ALU, jump and branch steps.
// Optional multiply/divide sequencing is compiled in when macro MULDIV_EN is defined.
module multicycle_ctrl #(
  parameter int LANES        = 4,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             funct7_0,
  input  logic             zero,
  input  logic             lt,
  input  logic [2:0]       addr_lo,
  input  logic             mem_ready,
  input  logic             md_done,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [LANES-1:0] MemWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic [2:0]       ImmSrc,
  output logic             illegal,
  output logic             md_start
);

`ifdef MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, JAL, JALR, BRANCH, MULDIV, HALT
  } state_t;

  state_t             state_reg, state_next;
  logic               illegal_reg, illegal_next;
  logic [LANES-1:0]   mask_reg, mask_next;
  logic [LANES-1:0]   lanes;
  logic               bad, mem_ok;
  logic [2:0]         imm_sel;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f75, input logic op5);
    case (f3)
      3'b000:  alu_dec = (op5 && f75) ? 4'b0001 : 4'b0000;
      3'b001:  alu_dec = 4'b0101;
      3'b010:  alu_dec = 4'b1000;
      3'b011:  alu_dec = 4'b1001;
      3'b100:  alu_dec = 4'b0100;
      3'b101:  alu_dec = f75 ? 4'b0111 : 4'b0110;
      3'b110:  alu_dec = 4'b0011;
      default: alu_dec = 4'b0010;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= FETCH;
      illegal_reg <= 1'b0;
      mask_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
      mask_reg    <= mask_next;
    end
  end

  assign illegal = illegal_reg;

  always_comb begin
    case (op)
      OP_STORE:         imm_sel = 3'b001;
      OP_BR:            imm_sel = 3'b010;
      OP_JAL:           imm_sel = 3'b011;
      OP_LUI, OP_AUIPC: imm_sel = 3'b100;
      default:          imm_sel = 3'b000;
    endcase
  end

  // Lane mask and alignment check, evaluated on the computed address in MEMADR
  always_comb begin
    lanes  = '0;
    mem_ok = 1'b0;
    case (funct3)
      3'b000, 3'b100: begin
        lanes  = LANES'(1) << addr_lo;
        mem_ok = (funct3 == 3'b000) || !op[5];
      end
      3'b001, 3'b101: begin
        lanes  = LANES'(2'b11) << addr_lo;
        mem_ok = !addr_lo[0] && ((funct3 == 3'b001) || !op[5]);
      end
      3'b010: begin
        if (LANES == 8) lanes = LANES'(4'hF) << {addr_lo[2], 2'b00};
        else            lanes = '1;
        mem_ok = (addr_lo[1:0] == 2'b00);
      end
      default: mem_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    illegal_next = ILLEGAL_HALT ? illegal_reg : 1'b0;
    mask_next    = mask_reg;
    bad          = 1'b0;
    PCWrite      = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    MemWrite     = '0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUControl   = 4'b0000;
    ImmSrc       = 3'b000;
    md_start     = 1'b0;
    // Outputs are forced low for as long as reset is held
    if (!reset) begin
      if (state_reg != HALT) ImmSrc = imm_sel;
      case (state_reg)
        FETCH: begin
          ResultSrc = 2'b10;
          ALUSrcB   = 2'b10;
          if (mem_ready) begin
            IRWrite    = 1'b1;
            PCWrite    = 1'b1;
            state_next = DECODE;
          end
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          case (op)
            OP_LOAD, OP_STORE: state_next = MEMADR;
            OP_R: begin
              if (!funct7_0)  state_next = EXECR;
              else if (MD_EN) state_next = MULDIV;
              else            bad = 1'b1;
            end
            OP_I:     state_next = EXECI;
            OP_JAL:   state_next = JAL;
            OP_JALR:  state_next = JALR;
            OP_BR:    state_next = BRANCH;
            OP_AUIPC: state_next = ALUWB;
            OP_LUI: begin
              RegWrite   = 1'b1;
              ResultSrc  = 2'b11;
              state_next = FETCH;
            end
            default: bad = 1'b1;
          endcase
        end
        MEMADR: begin
          ALUSrcA   = 2'b10;
          ALUSrcB   = 2'b01;
          mask_next = lanes;
          if (!mem_ok) bad = 1'b1;
          else         state_next = op[5] ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          AdrSrc = 1'b1;
          if (mem_ready) state_next = MEMWB;
        end
        MEMWB: begin
          ResultSrc  = 2'b01;
          RegWrite   = 1'b1;
          state_next = FETCH;
        end
        MEMWRITE: begin
          AdrSrc = 1'b1;
          if (mem_ready) begin
            MemWrite   = mask_reg;
            state_next = FETCH;
          end
        end
        EXECR, EXECI: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = (state_reg == EXECI) ? 2'b01 : 2'b00;
          ALUControl = alu_dec(funct3, funct7_5, op[5]);
          state_next = ALUWB;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          state_next = FETCH;
        end
        JAL: begin
          PCWrite    = 1'b1;
          ALUSrcA    = 2'b01;
          ALUSrcB    = 2'b10;
          state_next = ALUWB;
        end
        JALR: begin
          ALUSrcA    = 2'b10;
          ALUSrcB    = 2'b01;
          ResultSrc  = 2'b10;
          PCWrite    = 1'b1;
          state_next = ALUWB;
        end
        BRANCH: begin
          ALUSrcA    = 2'b10;
          state_next = FETCH;
          case (funct3)
            3'b000: begin ALUControl = 4'b0001; PCWrite = zero;  end
            3'b001: begin ALUControl = 4'b0001; PCWrite = !zero; end
            3'b100: begin ALUControl = 4'b1000; PCWrite = lt;    end
            3'b101: begin ALUControl = 4'b1000; PCWrite = !lt;   end
            3'b110: begin ALUControl = 4'b1001; PCWrite = lt;    end
            3'b111: begin ALUControl = 4'b1001; PCWrite = !lt;   end
            default: begin ALUControl = 4'b0001; bad = 1'b1;     end
          endcase
        end
        MULDIV: begin
          ALUSrcA  = 2'b10;
          md_start = MD_EN;
          if (md_done) state_next = ALUWB;
        end
        default: ;
      endcase
      if (bad) begin
        state_next   = ILLEGAL_HALT ? HALT : FETCH;
        illegal_next = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: stimulus pushes expected per-cycle output vectors, a monitor pops and compares.
module tb_multicycle_ctrl;
  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3, addr_lo;
  logic       funct7_5, funct7_0, zero, lt, mem_ready, md_done;
  logic       PCWrite, AdrSrc, IRWrite, RegWrite, illegal, md_start;
  logic [3:0] MemWrite, ALUControl;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;

  multicycle_ctrl #(.LANES(4), .ILLEGAL_HALT(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7_5(funct7_5),
    .funct7_0(funct7_0), .zero(zero), .lt(lt), .addr_lo(addr_lo),
    .mem_ready(mem_ready), .md_done(md_done), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .md_start(md_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [22:0] exp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [22:0] obs;
  assign obs = {PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ALUControl, ImmSrc, illegal, md_start};

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (obs !== e.exp) begin
        errors++;
        $display("FAIL %s got %h required %h", e.nm, obs, e.exp);
      end
    end
  end

  // Packs one expected output vector in the same field order as obs
  function automatic logic [22:0] E(input logic pcw, input logic adr, input logic irw,
                                    input logic rw, input logic [3:0] mw,
                                    input logic [1:0] rs, input logic [1:0] sa,
                                    input logic [1:0] sb, input logic [3:0] alu,
                                    input logic [2:0] imm, input logic ill, input logic mds);
    return {pcw, adr, irw, rw, mw, rs, sa, sb, alu, imm, ill, mds};
  endfunction

  function automatic logic [22:0] fetch_e(input logic rdy, input logic [2:0] imm);
    return E(rdy, 0, rdy, 0, 4'h0, 2'b10, 2'b00, 2'b10, 4'h0, imm, 0, 0);
  endfunction

  function automatic logic [22:0] decode_e(input logic [2:0] imm);
    return E(0, 0, 0, 0, 4'h0, 2'b00, 2'b01, 2'b01, 4'h0, imm, 0, 0);
  endfunction

  task automatic cyc(input string nm, input logic [22:0] e);
    exp_t x;
    x.nm  = nm;
    x.exp = e;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f75, input logic f70);
    op = o; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
  endtask

  task automatic do_alu(input string nm, input logic [6:0] o, input logic [2:0] f3,
                        input logic f75, input logic [3:0] alu);
    $display("txn %s", nm);
    set_instr(o, f3, f75, 1'b0);
    mem_ready = 1'b1;
    cyc({nm, "_fetch"}, fetch_e(1, 3'b000));
    cyc({nm, "_decode"}, decode_e(3'b000));
    cyc({nm, "_exec"}, E(0, 0, 0, 0, 4'h0, 2'b00, 2'b10, o[5] ? 2'b00 : 2'b01, alu, 3'b000, 0, 0));
    cyc({nm, "_wb"}, E(0, 0, 0, 1, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0));
  endtask

  task automatic do_branch(input string nm, input logic [2:0] f3, input logic ltv,
                           input logic zv, input logic pcw, input logic [3:0] alu);
    $display("txn %s", nm);
    set_instr(7'b1100011, f3, 1'b0, 1'b0);
    lt = ltv; zero = zv; mem_ready = 1'b1;
    cyc({nm, "_fetch"}, fetch_e(1, 3'b010));
    cyc({nm, "_decode"}, decode_e(3'b010));
    cyc({nm, "_branch"}, E(pcw, 0, 0, 0, 4'h0, 2'b00, 2'b10, 2'b00, alu, 3'b010, 0, 0));
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; md_done = 1'b0; zero = 1'b0; lt = 1'b0; addr_lo = 3'd0;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    @(posedge clk); #1;
    $display("txn reset");
    cyc("reset_outputs", 23'h0);
    reset = 1'b0;

    do_alu("add", 7'b0110011, 3'b000, 1'b0, 4'b0000);
    do_alu("sub", 7'b0110011, 3'b000, 1'b1, 4'b0001);
    do_alu("srai", 7'b0010011, 3'b101, 1'b1, 4'b0111);
    do_alu("addi_f7", 7'b0010011, 3'b000, 1'b1, 4'b0000);
    do_alu("sltu", 7'b0110011, 3'b011, 1'b0, 4'b1001);

    $display("txn lw_waits");
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    addr_lo = 3'd0; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_fetch_wait", fetch_e(0, 3'b000));
    mem_ready = 1'b1;
    cyc("lw_fetch", fetch_e(1, 3'b000));
    cyc("lw_decode", decode_e(3'b000));
    cyc("lw_memadr", E(0, 0, 0, 0, 4'h0, 2'b00, 2'b10, 2'b01, 4'h0, 3'b000, 0, 0));
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) cyc("lw_read_wait", E(0, 1, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0));
    mem_ready = 1'b1;
    cyc("lw_read", E(0, 1, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0));
    cyc("lw_memwb", E(0, 0, 0, 1, 4'h0, 2'b01, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0));

    $display("txn sb_addr3");
    set_instr(7'b0100011, 3'b000, 1'b0, 1'b0);
    addr_lo = 3'd3;
    cyc("sb_fetch", fetch_e(1, 3'b001));
    cyc("sb_decode", decode_e(3'b001));
    cyc("sb_memadr", E(0, 0, 0, 0, 4'h0, 2'b00, 2'b10, 2'b01, 4'h0, 3'b001, 0, 0));
    mem_ready = 1'b0;
    cyc("sb_write_wait", E(0, 1, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b001, 0, 0));
    mem_ready = 1'b1;
    cyc("sb_write", E(0, 1, 0, 0, 4'b1000, 2'b00, 2'b00, 2'b00, 4'h0, 3'b001, 0, 0));
    addr_lo = 3'd0;

    do_branch("blt_taken", 3'b100, 1'b1, 1'b0, 1'b1, 4'b1000);
    do_branch("bge_not", 3'b101, 1'b1, 1'b0, 1'b0, 4'b1000);
    do_branch("bne_taken", 3'b001, 1'b0, 1'b0, 1'b1, 4'b0001);
    do_branch("beq_not", 3'b000, 1'b0, 1'b0, 1'b0, 4'b0001);
    do_branch("bgeu_taken", 3'b111, 1'b0, 1'b1, 1'b1, 4'b1001);

    $display("txn jal");
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    cyc("jal_fetch", fetch_e(1, 3'b011));
    cyc("jal_decode", decode_e(3'b011));
    cyc("jal_jal", E(1, 0, 0, 0, 4'h0, 2'b00, 2'b01, 2'b10, 4'h0, 3'b011, 0, 0));
    cyc("jal_wb", E(0, 0, 0, 1, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b011, 0, 0));

    $display("txn lui");
    set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
    cyc("lui_fetch", fetch_e(1, 3'b100));
    cyc("lui_decode", E(0, 0, 0, 1, 4'h0, 2'b11, 2'b01, 2'b01, 4'h0, 3'b100, 0, 0));
    cyc("lui_next_fetch", fetch_e(1, 3'b100));

    $display("txn sw_reset");
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc("sw_decode", decode_e(3'b001));
    cyc("sw_memadr", E(0, 0, 0, 0, 4'h0, 2'b00, 2'b10, 2'b01, 4'h0, 3'b001, 0, 0));
    mem_ready = 1'b0;
    cyc("sw_write_wait", E(0, 1, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b001, 0, 0));
    reset = 1'b1;
    cyc("sw_reset_mid", 23'h0);
    reset = 1'b0;
    cyc("sw_after_reset", fetch_e(0, 3'b001));

    $display("txn mul");
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b1);
    mem_ready = 1'b1;
    cyc("mul_fetch", fetch_e(1, 3'b000));
    cyc("mul_decode", decode_e(3'b000));
`ifdef MULDIV_EN
    for (int i = 0; i < 5; i++) begin
      md_done = (i == 4);
      cyc("mul_start", E(0, 0, 0, 0, 4'h0, 2'b00, 2'b10, 2'b00, 4'h0, 3'b000, 0, 1));
    end
    md_done = 1'b0;
    cyc("mul_wb", E(0, 0, 0, 1, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 0, 0));
`else
    md_done = 1'b1;
    cyc("mul_halt", E(0, 0, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 1, 0));
    cyc("mul_halt_hold", E(0, 0, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 1, 0));
    md_done = 1'b0;
`endif
    reset = 1'b1;
    cyc("mul_reset", 23'h0);
    reset = 1'b0;

    $display("txn sh_misaligned");
    set_instr(7'b0100011, 3'b001, 1'b0, 1'b0);
    addr_lo = 3'd1;
    cyc("sh_fetch", fetch_e(1, 3'b001));
    cyc("sh_decode", decode_e(3'b001));
    cyc("sh_memadr", E(0, 0, 0, 0, 4'h0, 2'b00, 2'b10, 2'b01, 4'h0, 3'b001, 0, 0));
    for (int i = 0; i < 3; i++) cyc("sh_halt", E(0, 0, 0, 0, 4'h0, 2'b00, 2'b00, 2'b00, 4'h0, 3'b000, 1, 0));
    reset = 1'b1;
    cyc("final_reset", 23'h0);
    reset = 1'b0;
    cyc("final_fetch", fetch_e(1, 3'b001));

    @(posedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
